// File: rtl/if_inst_rdata_buffer_pkg.sv
// Shared definitions for the IF instruction-return buffer: instruction width,
// the {ok, rdata} inst-buffer bus width and the outstanding-counter update helper.
package if_inst_rdata_buffer_pkg;

    localparam int IF_INST_WIDTH      = 32;
    localparam int IF_INST_BUF_BUS_WD = IF_INST_WIDTH + 1;
    localparam int IBUF_STAT_WIDTH    = 32;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // An accept and a response in the same cycle cancel out.
    function automatic cnt_op_e cnt_op(input logic fire, input logic rsp);
        case ({fire, rsp})
            2'b10:   return CNT_INC;
            2'b01:   return CNT_DEC;
            default: return CNT_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/if_inst_rdata_buffer_discard_ctr.sv
// ibuf_discard_ctr: outstanding-fetch and stale-response counters, request
// back-pressure and the data_ok filter that hides killed fetches from IF.
module ibuf_discard_ctr
    import if_inst_rdata_buffer_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_fire,
    input  logic rsp,
    input  logic flush,
    output logic data_ok,
    output logic req_block,
    output logic discard_busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] out_cnt_next;
    logic [CNT_W-1:0] drop_cnt;

    // Saturating at both ends so protocol violations cannot wrap the count.
    always_comb begin
        out_cnt_next = out_cnt;
        unique case (cnt_op(req_fire, rsp))
            CNT_INC: if (out_cnt != MAX_CNT) out_cnt_next = out_cnt + CNT_W'(1);
            CNT_DEC: if (out_cnt != '0)      out_cnt_next = out_cnt - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_cnt_next;
            // Reload rather than accumulate: a request accepted in the flush
            // cycle is already counted in out_cnt_next and is stale too.
            if (flush) begin
                drop_cnt <= out_cnt_next;
            end else if (rsp && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    assign req_block    = (out_cnt == MAX_CNT);
    assign discard_busy = (drop_cnt != '0);
    assign data_ok      = rsp & ~discard_busy & ~flush;

endmodule

// File: rtl/if_inst_rdata_buffer.sv
// Instruction-return buffer between the inst-SRAM response path and IF.
// Optional IBUF_STAT_EN adds discard_total_o, a count of swallowed responses.
module if_inst_rdata_buffer
    import if_inst_rdata_buffer_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inst_sram_req_i,
    input  logic                     inst_sram_addr_ok_i,
    input  logic                     inst_sram_data_ok_i,
    input  logic [IF_INST_WIDTH-1:0] inst_sram_rdata_i,
    input  logic                     if_valid_i,
    input  logic                     id_allowin_i,
    input  logic                     flush_i,
    output logic                     inst_data_ok_o,
    output logic                     inst_rdata_buffer_ok_o,
    output logic [IF_INST_WIDTH-1:0] inst_rdata_buffer_rdata_o,
    output logic                     req_block_o,
    output logic                     discard_busy_o
`ifdef IBUF_STAT_EN
    ,
    output logic [IBUF_STAT_WIDTH-1:0] discard_total_o
`endif
);

    logic                          req_fire;
    logic                          buf_valid;
    logic [IF_INST_WIDTH-1:0]      buf_data;
    logic [IF_INST_BUF_BUS_WD-1:0] inst_buf_bus;
    logic                          buf_clear;
    logic                          buf_set;

    assign req_fire = inst_sram_req_i & inst_sram_addr_ok_i;

    ibuf_discard_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_discard_ctr (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_fire     (req_fire),
        .rsp          (inst_sram_data_ok_i),
        .flush        (flush_i),
        .data_ok      (inst_data_ok_o),
        .req_block    (req_block_o),
        .discard_busy (discard_busy_o)
    );

    assign buf_clear = (if_valid_i & id_allowin_i) | flush_i;
    assign buf_set   = inst_data_ok_o & if_valid_i & ~id_allowin_i & ~buf_valid;

    // Clear wins over set; a second word arriving while full is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (buf_clear) begin
            buf_valid <= 1'b0;
        end else if (buf_set) begin
            buf_valid <= 1'b1;
            buf_data  <= inst_sram_rdata_i;
        end
    end

    assign inst_buf_bus = {buf_valid, buf_data};
    assign {inst_rdata_buffer_ok_o, inst_rdata_buffer_rdata_o} = inst_buf_bus;

`ifdef IBUF_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard_total_o <= '0;
        end else if (inst_sram_data_ok_i && (discard_busy_o || flush_i)) begin
            discard_total_o <= discard_total_o + IBUF_STAT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_if_inst_rdata_buffer.sv
// Directed self-checking bench for if_inst_rdata_buffer (default parameters);
// covers the IBUF_STAT_EN counter when that macro is defined.
module tb_if_inst_rdata_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, aok, dok, ifv, idal, flush;
    logic [31:0] rdata;
    logic        data_ok, buf_ok, req_block, busy;
    logic [31:0] buf_rdata;
`ifdef IBUF_STAT_EN
    logic [31:0] discard_total;
`endif

    int checks   = 0;
    int failures = 0;
    bit          exp_pass_q[$];
    logic [31:0] exp_buf_q[$];

    always #5 clk = ~clk;

    if_inst_rdata_buffer #(
        .MAX_OUTSTANDING (2),
        .CNT_W           (3)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .inst_sram_req_i           (req),
        .inst_sram_addr_ok_i       (aok),
        .inst_sram_data_ok_i       (dok),
        .inst_sram_rdata_i         (rdata),
        .if_valid_i                (ifv),
        .id_allowin_i              (idal),
        .flush_i                   (flush),
        .inst_data_ok_o            (data_ok),
        .inst_rdata_buffer_ok_o    (buf_ok),
        .inst_rdata_buffer_rdata_o (buf_rdata),
        .req_block_o               (req_block),
        .discard_busy_o            (busy)
`ifdef IBUF_STAT_EN
        ,
        .discard_total_o           (discard_total)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check data_ok at negedge against the scoreboard,
    // return at posedge+1 with registered outputs updated.
    task automatic cyc(input logic r, input logic a, input logic d, input logic [31:0] rd,
                       input logic iv, input logic ia, input logic f, input bit pass);
        req = r; aok = a; dok = d; rdata = rd; ifv = iv; idal = ia; flush = f;
        if (d) exp_pass_q.push_back(pass);
        @(negedge clk);
        if (d) begin
            if (exp_pass_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
            else chk("data_ok", 32'(data_ok), 32'(exp_pass_q.pop_front()));
        end else begin
            chk("data_ok_idle", 32'(data_ok), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic ia);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, ia, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_ok"}, 32'(data_ok), 32'd0);
        chk({tag, "_buf_ok"}, 32'(buf_ok), 32'd0);
        chk({tag, "_buf_rdata"}, buf_rdata, 32'd0);
        chk({tag, "_req_block"}, 32'(req_block), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef IBUF_STAT_EN
        chk({tag, "_discard_total"}, discard_total, 32'd0);
`endif
    endtask

    task automatic idle_inputs();
        req = 0; aok = 0; dok = 0; rdata = '0; ifv = 0; idal = 0; flush = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Simple fetch
        fire(1'b1);
        cyc(0, 0, 0, 32'h0, 1, 1, 0, 0);
        cyc(0, 0, 1, 32'h02800C00, 1, 1, 0, 1);
        chk("simple_buf_ok", 32'(buf_ok), 32'd0);
        chk("simple_req_block", 32'(req_block), 32'd0);

        // ID stall capture, hold, second response ignored while full
        fire(1'b0);
        exp_buf_q.push_back(32'h1C000001);
        cyc(0, 0, 1, 32'h1C000001, 1, 0, 0, 1);
        chk("stall_buf_ok", 32'(buf_ok), 32'd1);
        chk("stall_buf_rdata", buf_rdata, exp_buf_q[0]);
        for (int i = 0; i < 5; i++) begin
            cyc(i == 1, i == 1, i == 3, 32'hDEADBEEF, 1, 0, 0, 1);
            chk("hold_buf_ok", 32'(buf_ok), 32'd1);
            chk("hold_buf_rdata", buf_rdata, exp_buf_q[0]);
        end
        cyc(0, 0, 0, 32'h0, 1, 1, 0, 0);
        chk("handoff_buf_ok", 32'(buf_ok), 32'd0);
        void'(exp_buf_q.pop_front());

        // Flush with two outstanding
        fire(1'b1);
        fire(1'b1);
        chk("two_out_req_block", 32'(req_block), 32'd1);
        cyc(0, 0, 0, 32'h0, 1, 1, 1, 0);
        chk("flush2_busy", 32'(busy), 32'd1);
        cyc(0, 0, 1, 32'h11111111, 1, 1, 0, 0);
        chk("stale1_busy", 32'(busy), 32'd1);
        cyc(0, 0, 1, 32'h22222222, 1, 1, 0, 0);
        chk("stale2_busy", 32'(busy), 32'd0);
`ifdef IBUF_STAT_EN
        chk("stat_after_flush2", discard_total, 32'd2);
`endif
        fire(1'b1);
        cyc(0, 0, 1, 32'h33333333, 1, 1, 0, 1);

        // Flush with simultaneous accept and response, one outstanding
        fire(1'b1);
        cyc(1, 1, 1, 32'h44444444, 1, 1, 1, 0);
        chk("flush_fire_busy", 32'(busy), 32'd1);
        cyc(0, 0, 1, 32'h55555555, 1, 1, 0, 0);
        chk("flush_fire_busy_done", 32'(busy), 32'd0);
`ifdef IBUF_STAT_EN
        chk("stat_after_flush_fire", discard_total, 32'd4);
`endif

        // Saturation and underflow
        fire(1'b1);
        fire(1'b1);
        chk("sat_req_block", 32'(req_block), 32'd1);
        fire(1'b1);
        chk("sat_over_req_block", 32'(req_block), 32'd1);
        cyc(0, 0, 1, 32'h66666666, 1, 1, 0, 1);
        chk("sat_release", 32'(req_block), 32'd0);
        cyc(0, 0, 1, 32'h77777777, 1, 1, 0, 1);
        cyc(0, 0, 1, 32'h88888888, 1, 1, 0, 1);
        fire(1'b1);
        chk("underflow_one_out", 32'(req_block), 32'd0);
        fire(1'b1);
        chk("underflow_two_out", 32'(req_block), 32'd1);

        // Back-to-back flushes reload rather than accumulate
        cyc(0, 0, 0, 32'h0, 1, 1, 1, 0);
        cyc(0, 0, 1, 32'h99999999, 1, 1, 0, 0);
        cyc(0, 0, 0, 32'h0, 1, 1, 1, 0);
        chk("reflush_busy", 32'(busy), 32'd1);
        cyc(0, 0, 1, 32'hAAAAAAAA, 1, 1, 0, 0);
        chk("reflush_busy_done", 32'(busy), 32'd0);
        chk("reflush_req_block", 32'(req_block), 32'd0);
`ifdef IBUF_STAT_EN
        chk("stat_after_reflush", discard_total, 32'd6);
`endif

        // Reset while buffer full and counters saturated
        fire(1'b1);
        fire(1'b1);
        cyc(0, 0, 1, 32'hA5A55A5A, 1, 0, 0, 1);
        fire(1'b0);
        chk("pre_reset_buf_ok", 32'(buf_ok), 32'd1);
        chk("pre_reset_req_block", 32'(req_block), 32'd1);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset_a");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("post_reset_a");

        // Reset while discarding
        fire(1'b1);
        cyc(0, 0, 0, 32'h0, 1, 1, 1, 0);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset_b");
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("post_reset_b");
        fire(1'b1);
        cyc(0, 0, 1, 32'hBBBBBBBB, 1, 1, 0, 1);
        chk("post_reset_req_block", 32'(req_block), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
